pipe_stage_elastic: RTL and testbench

Parametrised, elastic successor to the fixed-field stage latches (fetch/decode, decode/execute, ...): one generic pipeline stage register that carries an opaque WIDTH-bit payload (packed stage bundle) with a valid/ready handshake, a 2-entry skid buffer, flush, and bubble insertion. Every inter-stage boundary of the pipelined datapath instantiates it, so stall/flush logic lives in the hazard unit, not in per-stage latches. in_ready depends only on registered state, which breaks the backward combinational stall path.

---
 rtl/pipe_stage_elastic_pkg.sv | 43 ++++
 rtl/pipe_stage_elastic_if.sv | 30 +++
 rtl/pipe_stage_elastic_sat_counter.sv | 40 ++++
 rtl/pipe_stage_elastic.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types for the elastic pipeline stage: the stage-state
//               enum and example packed stage bundles used to size WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Default payload width when a stage is not sized from a bundle type.
  localparam int unsigned PIPE_DEFAULT_W = 32;

  // Occupancy of one elastic stage: nothing held, head only, head + skid.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_HALF  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  // Fetch/decode boundary bundle.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_bundle_t;

  // Decode/execute boundary bundle.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } idex_bundle_t;

  localparam int unsigned PIPE_IFID_W = $bits(ifid_bundle_t);
  localparam int unsigned PIPE_IDEX_W = $bits(idex_bundle_t);

endpackage
`default_nettype wire

// File: rtl/pipe_stage_elastic_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_elastic_if
// Description : Valid/ready handshake bundle around one elastic stage.
//               master = environment view, slave = stage view.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_elastic_if
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_DEFAULT_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_elastic_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_counter
// Description : Up-counter that sticks at its all-ones value. Synchronous
//               active-high reset is the only way to clear it.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             inc_i,
  output logic      [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Increment unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_elastic
// Description : Generic elastic pipeline stage register: opaque WIDTH-bit
//               payload, valid/ready handshake, 2-entry skid buffer, flush.
//               in_ready is a function of registered state only, so stall
//               does not ripple combinationally upstream.
//               Optional statistics counters under macro PIPE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH      = PIPE_DEFAULT_W,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int unsigned      CNT_W      = 16
) (
  input  wire logic             CLK,
  input  wire logic             RST,
  input  wire logic             flush,
  pipe_stage_elastic_if.slave   pif
`ifdef PIPE_STATS_EN
  ,
  output logic      [CNT_W-1:0] stall_cnt,
  output logic      [CNT_W-1:0] flush_cnt
`endif
);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;

  logic             out_valid;
  logic             in_ready;
  logic             in_fire;
  logic             out_fire;

  // Handshake outputs come straight from the state register.
  assign out_valid     = (state_q != PS_EMPTY);
  assign in_ready      = (state_q != PS_FULL);
  assign in_fire       = pif.in_valid & in_ready;
  assign out_fire      = out_valid & pif.out_ready;

  assign pif.out_valid = out_valid;
  assign pif.in_ready  = in_ready;
  assign pif.out_data  = main_q;

  // Next-state and storage update; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A same-cycle out_fire still completes: downstream already took main_q.
      state_d = PS_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d = PS_HALF;
            main_d  = pif.in_data;
          end
        end
        PS_HALF: begin
          if (in_fire && out_fire) begin
            main_d = pif.in_data;
          end else if (in_fire) begin
            state_d = PS_FULL;
            skid_d  = pif.in_data;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        PS_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_d = PS_HALF;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = PS_EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // State and payload registers; reset outranks flush.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= PS_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STATS_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = out_valid & ~pif.out_ready;
  // Only flushes that actually squash something are counted.
  assign flush_inc = flush & out_valid;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );
`else
  // Counters compiled out; CNT_W is kept so instantiations are identical
  // in both builds.
  if (CNT_W == 0) begin : g_stats_off
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_elastic
// Description : Self-checking bench for pipe_stage_elastic. A queue model
//               (capacity 2, FIFO order, flush empties it) predicts the
//               outputs every cycle; literal checks pin key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 2;
  localparam int          CMAX = 3;

  logic CLK = 1'b0;
  logic RST;
  logic flush;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  pipe_stage_elastic_if #(.WIDTH(W)) pif ();

  pipe_stage_elastic #(
    .WIDTH      (W),
    .BUBBLE_VAL ('0),
    .CNT_W      (CW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .pif       (pif)
`ifdef PIPE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

`ifndef PIPE_STATS_EN
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a bounded queue plus two saturating tallies.
  logic [W-1:0] mq[$];
  int m_stall = 0;
  int m_flush = 0;

  always @(posedge CLK) begin
    if (RST) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      bit mv, mr;
      mv = (mq.size() != 0);
      mr = (mq.size() < 2);
      if (mv && !pif.out_ready && m_stall < CMAX) m_stall++;
      if (flush && mv && m_flush < CMAX) m_flush++;
      if (flush) begin
        mq.delete();
      end else begin
        if (mv && pif.out_ready) void'(mq.pop_front());
        if (pif.in_valid && mr) mq.push_back(pif.in_data);
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      logic [W-1:0] exp_d;
      exp_d = (mq.size() != 0) ? mq[0] : '0;
      chk("m_out_valid", 32'(pif.out_valid), 32'(mq.size() != 0));
      chk("m_in_ready",  32'(pif.in_ready),  32'(mq.size() < 2));
      chk("m_out_data",  pif.out_data, exp_d);
`ifdef PIPE_STATS_EN
      chk("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("m_flush_cnt", 32'(flush_cnt), 32'(m_flush));
`endif
    end
  end

  // One clock of stimulus: drive, take the edge, settle just after it.
  task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f);
    pif.in_valid  = v;
    pif.in_data   = d;
    pif.out_ready = r;
    flush         = f;
    @(posedge CLK);
    #2;
  endtask

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        f;
  } vec_t;

  vec_t mix [12];

  initial begin
    mix[0]  = '{1'b1, 32'h11, 1'b0, 1'b0};
    mix[1]  = '{1'b1, 32'h22, 1'b1, 1'b0};
    mix[2]  = '{1'b1, 32'h33, 1'b0, 1'b0};
    mix[3]  = '{1'b1, 32'h44, 1'b0, 1'b0};
    mix[4]  = '{1'b0, 32'h00, 1'b1, 1'b0};
    mix[5]  = '{1'b1, 32'h55, 1'b1, 1'b0};
    mix[6]  = '{1'b1, 32'h66, 1'b1, 1'b1};
    mix[7]  = '{1'b1, 32'h77, 1'b0, 1'b0};
    mix[8]  = '{1'b0, 32'h00, 1'b0, 1'b0};
    mix[9]  = '{1'b1, 32'h88, 1'b1, 1'b0};
    mix[10] = '{1'b0, 32'h00, 1'b1, 1'b0};
    mix[11] = '{1'b0, 32'h00, 1'b1, 1'b0};

    RST = 1'b1;
    pif.in_valid = 1'b0;
    pif.in_data = '0;
    pif.out_ready = 1'b0;
    flush = 1'b0;
    @(posedge CLK);
    #2;
    chk_en = 1'b1;
    @(posedge CLK);
    #2;
    RST = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(pif.out_valid), 32'd0);
    chk("rst_in_ready",  32'(pif.in_ready),  32'd1);
    chk("rst_out_data",  pif.out_data,       32'h0);
`ifdef PIPE_STATS_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif

    // Streaming, no stall
    cyc(1'b1, 32'h1, 1'b1, 1'b0);
    chk("stream_d1", pif.out_data, 32'h1);
    cyc(1'b1, 32'h2, 1'b1, 1'b0);
    chk("stream_d2", pif.out_data, 32'h2);
    cyc(1'b1, 32'h3, 1'b1, 1'b0);
    chk("stream_d3", pif.out_data, 32'h3);
    chk("stream_rdy", 32'(pif.in_ready), 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stream_drain", 32'(pif.out_valid), 32'd0);

    // Stall: fill to FULL, hold 0xC off, then drain in order
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    chk("stall_full_rdy", 32'(pif.in_ready), 32'd0);
    chk("stall_head_a", pif.out_data, 32'hA);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    chk("stall_hold_a", pif.out_data, 32'hA);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    chk("stall_head_b", pif.out_data, 32'hB);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    chk("stall_head_c", pif.out_data, 32'hC);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stall_empty", 32'(pif.out_valid), 32'd0);
`ifdef PIPE_STATS_EN
    chk("stall_cnt_2", 32'(stall_cnt), 32'd2);
`endif

    // Flush while FULL with 0xC offered
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b1);
    chk("flush_valid", 32'(pif.out_valid), 32'd0);
    chk("flush_data",  pif.out_data,       32'h0);
    chk("flush_rdy",   32'(pif.in_ready),  32'd1);
`ifdef PIPE_STATS_EN
    chk("flush_cnt_1", 32'(flush_cnt), 32'd1);
`endif
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_no_c", 32'(pif.out_valid), 32'd0);

    // Flush with head 0x5 being consumed, then flush while empty
    cyc(1'b1, 32'h5, 1'b1, 1'b0);
    chk("head_5", pif.out_data, 32'h5);
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    chk("flush5_empty", 32'(pif.out_valid), 32'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
`ifdef PIPE_STATS_EN
    chk("flush_cnt_empty", 32'(flush_cnt), 32'd2);
`endif

    // Reset mid-stall with flush asserted
    cyc(1'b1, 32'h7, 1'b0, 1'b0);
    cyc(1'b1, 32'h8, 1'b0, 1'b0);
    RST = 1'b1;
    cyc(1'b1, 32'h9, 1'b0, 1'b1);
    RST = 1'b0;
    chk("rst_mid_valid", 32'(pif.out_valid), 32'd0);
    chk("rst_mid_rdy",   32'(pif.in_ready),  32'd1);
`ifdef PIPE_STATS_EN
    chk("rst_mid_stall", 32'(stall_cnt), 32'd0);
    chk("rst_mid_flush", 32'(flush_cnt), 32'd0);
`endif

    // Saturation: five stalled cycles with CNT_W=2
    cyc(1'b1, 32'h9, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sat_head", pif.out_data, 32'h9);
`ifdef PIPE_STATS_EN
    chk("sat_stall_3", 32'(stall_cnt), 32'd3);
`endif
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Mixed directed patterns, checked by the model
    for (int i = 0; i < 12; i++) cyc(mix[i].v, mix[i].d, mix[i].r, mix[i].f);

    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
